hazard_stall_ctrl: RTL and testbench

//   Hazard and stall controller for the 5-stage pipeline. It is the producer side of the
//   EX-stage operand-bypass path: it flags hazards that bypassing cannot resolve and

---
 rtl/hazard_stall_ctrl.sv | 134 +++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall controller for the 5-stage pipeline.
// Flags load-use hazards that EX bypassing cannot resolve and inserts one bubble for each.
// Flushes IF/ID on a taken branch.
// Freezes the whole pipeline while a MEM-stage access waits for its acknowledge.
// Counts stall cycles with a saturating counter and keeps a sticky memory-timeout flag.
module hazard_stall_ctrl #(
    parameter int CNT_W       = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       ID_RS1_i,
    input  logic [4:0]       ID_RS2_i,
    input  logic [4:0]       EX_RD_i,
    input  logic             EX_MemRead_i,
    input  logic             ID_BranchTaken_i,
    input  logic             MEM_Req_i,
    input  logic             MEM_Ack_i,
    output logic             PCWrite_o,
    output logic             IF_ID_Write_o,
    output logic             IF_ID_Flush_o,
    output logic             ID_EX_Bubble_o,
    output logic             Freeze_o,
    output logic [CNT_W-1:0] StallCnt_o,
    output logic             MemTimeout_o
);

    // Wide enough to hold TIMEOUT_CYC itself, because the timeout test compares against it.
    localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              timeout_q, timeout_d;

    logic load_use;
    logic mem_busy;

    // A load in EX whose destination feeds ID cannot be bypassed in time.
    // Register x0 is never a real dependency.
    assign load_use = EX_MemRead_i && (EX_RD_i != 5'd0) &&
                      ((EX_RD_i == ID_RS1_i) || (EX_RD_i == ID_RS2_i));

    // An access that is not acknowledged in its first cycle freezes the pipeline.
    // That first cycle already counts as frozen.
    assign mem_busy = (state_q == MEM_WAIT) ||
                      ((state_q == RUN) && MEM_Req_i && !MEM_Ack_i);

    // Pipeline control outputs, prioritised: memory freeze, then load-use, then branch.
    always_comb begin
        // NOTE: every output gets a default first, so no path through the block can infer a latch.
        PCWrite_o      = 1'b1;
        IF_ID_Write_o  = 1'b1;
        IF_ID_Flush_o  = 1'b0;
        ID_EX_Bubble_o = 1'b0;
        Freeze_o       = 1'b0;
        if (mem_busy) begin
            Freeze_o      = 1'b1;
            PCWrite_o     = 1'b0;
            IF_ID_Write_o = 1'b0;
        end else if (load_use) begin
            PCWrite_o      = 1'b0;
            IF_ID_Write_o  = 1'b0;
            ID_EX_Bubble_o = 1'b1;
        end else if (ID_BranchTaken_i) begin
            IF_ID_Flush_o = 1'b1;
        end
    end

    // Next state for the memory-wait FSM, the wait counter and the timeout flag.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        unique case (state_q)
            RUN: begin
                if (MEM_Req_i && !MEM_Ack_i) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                // Dropping MEM_Req_i here has no effect; only an ack or a timeout leaves the wait.
                if (MEM_Ack_i) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_W'(TIMEOUT_CYC)) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                    timeout_d  = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Saturating stall counter: it holds at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((Freeze_o || load_use) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: use non-blocking assignments for registers, so every flop samples values from before the edge.
        if (rst_i) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign StallCnt_o   = stall_cnt_q;
    assign MemTimeout_o = timeout_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl.
// Two configurations share the same stimulus:
//   A: CNT_W=3, TIMEOUT_CYC=4 (saturation and timeout corners)
//   B: CNT_W=8, TIMEOUT_CYC=6
// A driver issues one stimulus per cycle and pushes the expected response of each configuration.
// A monitor pops each entry at the falling edge and compares it with both DUTs.
module tb_hazard_stall_ctrl;

    localparam int A_CNT_W = 3;
    localparam int A_TMO   = 4;
    localparam int B_CNT_W = 8;
    localparam int B_TMO   = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_i, memread_i, br_i, req_i, ack_i;
    logic [4:0] rs1_i, rs2_i, rd_i;

    logic               a_pcw, a_ifw, a_flush, a_bubble, a_freeze, a_tmo;
    logic [A_CNT_W-1:0] a_cnt;
    logic               b_pcw, b_ifw, b_flush, b_bubble, b_freeze, b_tmo;
    logic [B_CNT_W-1:0] b_cnt;

    hazard_stall_ctrl #(.CNT_W(A_CNT_W), .TIMEOUT_CYC(A_TMO)) dut_a (
        .clk_i(clk), .rst_i(rst_i), .ID_RS1_i(rs1_i), .ID_RS2_i(rs2_i),
        .EX_RD_i(rd_i), .EX_MemRead_i(memread_i), .ID_BranchTaken_i(br_i),
        .MEM_Req_i(req_i), .MEM_Ack_i(ack_i),
        .PCWrite_o(a_pcw), .IF_ID_Write_o(a_ifw), .IF_ID_Flush_o(a_flush),
        .ID_EX_Bubble_o(a_bubble), .Freeze_o(a_freeze), .StallCnt_o(a_cnt),
        .MemTimeout_o(a_tmo)
    );

    hazard_stall_ctrl #(.CNT_W(B_CNT_W), .TIMEOUT_CYC(B_TMO)) dut_b (
        .clk_i(clk), .rst_i(rst_i), .ID_RS1_i(rs1_i), .ID_RS2_i(rs2_i),
        .EX_RD_i(rd_i), .EX_MemRead_i(memread_i), .ID_BranchTaken_i(br_i),
        .MEM_Req_i(req_i), .MEM_Ack_i(ack_i),
        .PCWrite_o(b_pcw), .IF_ID_Write_o(b_ifw), .IF_ID_Flush_o(b_flush),
        .ID_EX_Bubble_o(b_bubble), .Freeze_o(b_freeze), .StallCnt_o(b_cnt),
        .MemTimeout_o(b_tmo)
    );

    typedef struct packed {
        logic       rst, memread, br, req, ack;
        logic [4:0] rs1, rs2, rd;
    } stim_t;

    typedef struct packed {
        logic        pcw, ifw, flush, bubble, freeze, tmo;
        logic [31:0] cnt;
    } exp_t;

    typedef struct packed {
        exp_t a;
        exp_t b;
    } rec_t;

    // Abstract model state: whether an access is pending, how long it has waited,
    // the unbounded stall count (clipped at the width's maximum) and the sticky flag.
    typedef struct {
        bit     waiting;
        int     waited;
        longint stall;
        bit     tmo;
    } mstate_t;

    rec_t    sb_q[$];
    mstate_t ma, mb;
    int      compared   = 0;
    int      mismatched = 0;

    function automatic bit is_load_use(stim_t x);
        return x.memread && (x.rd != 5'd0) && ((x.rd == x.rs1) || (x.rd == x.rs2));
    endfunction

    function automatic exp_t model_out(mstate_t s, stim_t x);
        exp_t e;
        e     = '0;
        e.cnt = 32'(s.stall);
        e.tmo = s.tmo;
        if (s.waiting || (x.req && !x.ack)) begin
            e.freeze = 1'b1;
        end else if (is_load_use(x)) begin
            e.bubble = 1'b1;
        end else begin
            e.pcw   = 1'b1;
            e.ifw   = 1'b1;
            e.flush = x.br;
        end
        return e;
    endfunction

    function automatic mstate_t model_next(mstate_t s, stim_t x, int cnt_w, int tmo_cyc);
        mstate_t n;
        exp_t    e;
        longint  cap;
        n   = s;
        e   = model_out(s, x);
        cap = (longint'(1) << cnt_w) - 1;
        if (x.rst) begin
            n.waiting = 0;
            n.waited  = 0;
            n.stall   = 0;
            n.tmo     = 0;
            return n;
        end
        if ((e.freeze || is_load_use(x)) && (n.stall < cap)) n.stall = n.stall + 1;
        if (!s.waiting) begin
            if (x.req && !x.ack) begin
                n.waiting = 1;
                n.waited  = 1;
            end
        end else if (x.ack) begin
            n.waiting = 0;
            n.waited  = 0;
        end else if (s.waited == tmo_cyc) begin
            n.waiting = 0;
            n.waited  = 0;
            n.tmo     = 1;
        end else begin
            n.waited = s.waited + 1;
        end
        return n;
    endfunction

    task automatic cmp(string tag, logic [31:0] act, logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", tag, $time, act, req);
        end
    endtask

    task automatic step(stim_t x);
        rec_t r;
        @(posedge clk);
        #1;
        rst_i     = x.rst;
        memread_i = x.memread;
        br_i      = x.br;
        req_i     = x.req;
        ack_i     = x.ack;
        rs1_i     = x.rs1;
        rs2_i     = x.rs2;
        rd_i      = x.rd;
        r.a = model_out(ma, x);
        r.b = model_out(mb, x);
        sb_q.push_back(r);
        ma = model_next(ma, x, A_CNT_W, A_TMO);
        mb = model_next(mb, x, B_CNT_W, B_TMO);
    endtask

    // Monitor: compares both DUTs against the oldest expectation every falling edge.
    initial begin
        rec_t r;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                r = sb_q.pop_front();
                cmp("A.PCWrite",   32'(a_pcw),    32'(r.a.pcw));
                cmp("A.IF_ID_Wr",  32'(a_ifw),    32'(r.a.ifw));
                cmp("A.Flush",     32'(a_flush),  32'(r.a.flush));
                cmp("A.Bubble",    32'(a_bubble), 32'(r.a.bubble));
                cmp("A.Freeze",    32'(a_freeze), 32'(r.a.freeze));
                cmp("A.StallCnt",  32'(a_cnt),    r.a.cnt);
                cmp("A.Timeout",   32'(a_tmo),    32'(r.a.tmo));
                cmp("B.PCWrite",   32'(b_pcw),    32'(r.b.pcw));
                cmp("B.IF_ID_Wr",  32'(b_ifw),    32'(r.b.ifw));
                cmp("B.Flush",     32'(b_flush),  32'(r.b.flush));
                cmp("B.Bubble",    32'(b_bubble), 32'(r.b.bubble));
                cmp("B.Freeze",    32'(b_freeze), 32'(r.b.freeze));
                cmp("B.StallCnt",  32'(b_cnt),    r.b.cnt);
                cmp("B.Timeout",   32'(b_tmo),    32'(r.b.tmo));
            end
        end
    end

    initial begin
        stim_t q, x;
        q = '0;
        rst_i = 1'b1; memread_i = 1'b0; br_i = 1'b0; req_i = 1'b0; ack_i = 1'b0;
        rs1_i = '0; rs2_i = '0; rd_i = '0;
        ma = '{waiting: 0, waited: 0, stall: 0, tmo: 0};
        mb = '{waiting: 0, waited: 0, stall: 0, tmo: 0};
        repeat (2) @(posedge clk);

        // Reset state
        step(q); step(q);

        // Load-use on rs2: one bubble, then the counter reads 1
        x = q; x.memread = 1; x.rd = 5'd5; x.rs2 = 5'd5; x.rs1 = 5'd3;
        step(x); step(q);

        // Load to x0 with rs1=x0: no stall
        x = q; x.memread = 1; x.rd = 5'd0; x.rs1 = 5'd0;
        step(x); step(q);

        // Three wait cycles then ack, with a branch held during the freeze
        x = q; x.req = 1; x.br = 1;
        repeat (3) step(x);
        x.ack = 1; step(x);
        step(q);

        // Load-use together with a taken branch, then the branch alone
        x = q; x.memread = 1; x.rd = 5'd7; x.rs1 = 5'd7; x.br = 1;
        step(x);
        x = q; x.br = 1; step(x);

        // No ack: A times out after five freeze cycles; B keeps waiting until its own limit
        x = q; x.req = 1;
        repeat (5) step(x);
        repeat (6) step(q);

        // Long freeze saturates the narrow counter; reset mid-wait clears everything
        x = q; x.rst = 1; step(x);
        x = q; x.req = 1;
        repeat (10) step(x);
        x.rst = 1; step(x);
        step(q); step(q);

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            x.rst     = ($urandom_range(0, 60) == 0);
            x.memread = 1'($urandom_range(0, 1));
            x.br      = 1'($urandom_range(0, 1));
            x.req     = ($urandom_range(0, 2) == 0);
            x.ack     = ($urandom_range(0, 3) == 0);
            x.rs1     = 5'($urandom_range(0, 3));
            x.rs2     = 5'($urandom_range(0, 3));
            x.rd      = 5'($urandom_range(0, 3));
            step(x);
        end

        step(q);
        @(negedge clk);
        #1;
        cmp("scoreboard_drain", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
